// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES definitions: state geometry, affine constant, iterative-engine FSM
// states and the GF(2^8) inverse used by the S-box lanes.
package inv_sub_bytes_iter_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES = 16;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_iter_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero for free.
    function automatic logic [7:0] ninv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Input/output valid-ready channels of the iterative InvSubBytes engine.
interface inv_sub_bytes_iter_if;
    import inv_sub_bytes_iter_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_data;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// One combinational AES inverse S-box lane: inverse affine map, then GF(2^8) inverse.
module inv_sbox
    import inv_sub_bytes_iter_pkg::*;
(
    input  logic [7:0] s,
    output logic [7:0] y
);

    logic [7:0] x;

    // Bit i of each rotate-right term is s[i+k mod 8] for k = 2, 5, 7.
    assign x = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ INV_AFFINE_C;
    assign y = ninv(x);

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the held state
// per clock, then presents the full result over a valid/ready handshake.
module inv_sub_bytes_iter
    import inv_sub_bytes_iter_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input logic clk,
    input logic rst,
    inv_sub_bytes_iter_if.slave bus
);

    localparam int NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
    localparam int LANE_W = BYTES_PER_CYCLE * 8;
    localparam int CNT_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    aes_iter_state_e        fsm_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_STATE_W-1:0] state_q;
    logic [AES_STATE_W-1:0] out_data_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [7:0]             shift;
    logic [LANE_W-1:0]      sel;
    logic [LANE_W-1:0]      lane_out;
    logic [AES_STATE_W-1:0] repl;
    logic [AES_STATE_W-1:0] mask;
    logic [AES_STATE_W-1:0] state_next;
    logic                   last_step;

    // Byte k sits at the MSB end, so the active window is found by shifting left.
    assign shift = 8'(cnt_q) * 8'(LANE_W);
    assign sel = LANE_W'((state_q << shift) >> (AES_STATE_W - LANE_W));

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .s(sel[LANE_W-1-8*l -: 8]),
            .y(lane_out[LANE_W-1-8*l -: 8])
        );
    end

    assign repl = (AES_STATE_W'(lane_out) << (AES_STATE_W - LANE_W)) >> shift;
    assign mask = (AES_STATE_W'({LANE_W{1'b1}}) << (AES_STATE_W - LANE_W)) >> shift;
    assign state_next = (state_q & ~mask) | repl;
    assign last_step = (cnt_q == CNT_W'(NUM_STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        state_q    <= bus.in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        fsm_q      <= BUSY;
                    end
                end
                BUSY: begin
                    state_q <= state_next;
                    if (last_step) begin
                        out_data_q  <= state_next;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: one DUT per lane count, checked against an inverse
// table derived from the forward AES S-box definition.
module tb_inv_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_sub_bytes_iter_if if_b1 ();
    inv_sub_bytes_iter_if if_b2 ();
    inv_sub_bytes_iter_if if_b4 ();
    inv_sub_bytes_iter_if if_b8 ();
    inv_sub_bytes_iter_if if_b16 ();

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1))  u_dut_b1  (.clk(clk), .rst(rst), .bus(if_b1.slave));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(2))  u_dut_b2  (.clk(clk), .rst(rst), .bus(if_b2.slave));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4))  u_dut_b4  (.clk(clk), .rst(rst), .bus(if_b4.slave));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(8))  u_dut_b8  (.clk(clk), .rst(rst), .bus(if_b8.slave));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut_b16 (.clk(clk), .rst(rst), .bus(if_b16.slave));

    int n_cmp = 0;
    int n_fail = 0;
    int bpc_of[5] = '{1, 2, 4, 8, 16};

    logic [7:0] fwd_tbl[256];
    logic [7:0] inv_tbl[256];

    // Reference model: forward S-box from its textbook definition, inverted as a lookup.
    function automatic logic [7:0] ref_mul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ a;
            a = a << 1;
            if (a & 'h100) a = a ^ 'h11b;
        end
        return 8'(p);
    endfunction

    function automatic logic [7:0] ref_fwd(input int x);
        int b = 0;
        int r;
        for (int y = 1; y < 256; y++) if (x != 0 && ref_mul(x, y) == 8'h01) b = y;
        r = b;
        for (int k = 1; k <= 4; k++) r = r ^ (((b << k) | (b >> (8 - k))) & 'hff);
        return 8'(r ^ 'h63);
    endfunction

    function automatic logic [127:0] model_inv(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tbl[s[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fwd_tbl[s[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Call at a post-edge instant; returns one post-edge instant after the output handshake.
    task automatic run_txn(virtual inv_sub_bytes_iter_if vif, input logic [127:0] din,
                           output logic [127:0] dout, output int lat, output bit to);
        int w = 0;
        to = 0;
        lat = 0;
        dout = '0;
        while (!vif.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        if (!vif.in_ready) begin to = 1; return; end
        vif.in_data = din;
        vif.in_valid = 1'b1;
        @(posedge clk); #1;
        vif.in_valid = 1'b0;
        while (!vif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!vif.out_valid) begin to = 1; return; end
        dout = vif.out_data;
        vif.out_ready = 1'b1;
        @(posedge clk); #1;
        vif.out_ready = 1'b0;
    endtask

    task automatic do_txn(input int idx, input logic [127:0] din,
                          output logic [127:0] dout, output int lat, output bit to);
        case (idx)
            0: run_txn(if_b1, din, dout, lat, to);
            1: run_txn(if_b2, din, dout, lat, to);
            2: run_txn(if_b4, din, dout, lat, to);
            3: run_txn(if_b8, din, dout, lat, to);
            default: run_txn(if_b16, din, dout, lat, to);
        endcase
    endtask

    task automatic test_reset();
        n_cmp++;
        if (if_b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", if_b4.in_ready); end
        n_cmp++;
        if (if_b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", if_b4.out_valid); end
        n_cmp++;
        if (if_b4.out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", if_b4.out_data); end
        n_cmp++;
        if (if_b4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", if_b4.busy); end
        n_cmp++;
        if ({if_b1.in_ready, if_b2.in_ready, if_b8.in_ready, if_b16.in_ready} !== 4'hf) begin
            n_fail++;
            $display("FAIL reset_in_ready_all got=%b exp=1111",
                     {if_b1.in_ready, if_b2.in_ready, if_b8.in_ready, if_b16.in_ready});
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] d;
        int lat;
        bit to;
        do_txn(2, {16{8'h63}}, d, lat, to);
        n_cmp++;
        if (to || d !== 128'h0) begin n_fail++; $display("FAIL all63 got=%h exp=0 timeout=%0d", d, to); end
        n_cmp++;
        if (lat != 4) begin n_fail++; $display("FAIL all63_latency got=%0d exp=4", lat); end
        do_txn(2, 128'h637C_0000_ED16_0000_0000_0000_0000_0000, d, lat, to);
        n_cmp++;
        if (to || d !== {8'h00, 8'h01, 8'h52, 8'h52, 8'h53, 8'hFF, {10{8'h52}}}) begin
            n_fail++;
            $display("FAIL pattern2 got=%h exp=%h", d, {8'h00, 8'h01, 8'h52, 8'h52, 8'h53, 8'hFF, {10{8'h52}}});
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] din;
        logic [127:0] held;
        logic [127:0] d;
        int w = 0;
        int lat;
        bit to;
        din = rand_state();
        if_b4.in_data = din;
        if_b4.in_valid = 1'b1;
        @(posedge clk); #1;
        if_b4.in_valid = 1'b0;
        while (!if_b4.out_valid && w < 40) begin @(posedge clk); #1; w++; end
        held = if_b4.out_data;
        n_cmp++;
        if (!if_b4.out_valid || held !== model_inv(din)) begin
            n_fail++; $display("FAIL bp_result got=%h exp=%h valid=%b", held, model_inv(din), if_b4.out_valid);
        end
        if_b4.in_data = rand_state();
        if_b4.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (if_b4.out_data !== held || if_b4.in_ready !== 1'b0 || if_b4.out_valid !== 1'b1 || if_b4.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d data=%h exp=%h in_ready=%b out_valid=%b busy=%b",
                         c, if_b4.out_data, held, if_b4.in_ready, if_b4.out_valid, if_b4.busy);
            end
        end
        if_b4.in_valid = 1'b0;
        if_b4.out_ready = 1'b1;
        @(posedge clk); #1;
        if_b4.out_ready = 1'b0;
        n_cmp++;
        if (if_b4.in_ready !== 1'b1 || if_b4.out_valid !== 1'b0 || if_b4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b exp=1/0/0",
                     if_b4.in_ready, if_b4.out_valid, if_b4.busy);
        end
        n_cmp++;
        if (if_b4.out_data !== held) begin n_fail++; $display("FAIL bp_out_held got=%h exp=%h", if_b4.out_data, held); end
        din = rand_state();
        do_txn(2, din, d, lat, to);
        n_cmp++;
        if (to || d !== model_inv(din)) begin n_fail++; $display("FAIL bp_next got=%h exp=%h", d, model_inv(din)); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] din;
        logic [127:0] d;
        int lat;
        bit to;
        if_b4.in_data = rand_state();
        if_b4.in_valid = 1'b1;
        @(posedge clk); #1;
        if_b4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (if_b4.in_ready !== 1'b1 || if_b4.out_valid !== 1'b0 || if_b4.out_data !== 128'h0 || if_b4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset in_ready=%b out_valid=%b out_data=%h busy=%b exp=1/0/0/0",
                     if_b4.in_ready, if_b4.out_valid, if_b4.out_data, if_b4.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (if_b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_output got=%b exp=0", if_b4.out_valid); end
        din = rand_state();
        do_txn(2, din, d, lat, to);
        n_cmp++;
        if (to || d !== model_inv(din) || lat != 4) begin
            n_fail++; $display("FAIL midreset_after got=%h exp=%h lat=%0d", d, model_inv(din), lat);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] din;
        logic [127:0] d;
        int lat;
        bit to;
        for (int idx = 0; idx < 5; idx++) begin
            for (int s = 0; s < 16; s++) begin
                for (int k = 0; k < 16; k++) din[127-8*k -: 8] = 8'(s * 16 + k);
                do_txn(idx, din, d, lat, to);
                n_cmp++;
                if (to || d !== model_inv(din)) begin
                    n_fail++; $display("FAIL sweep bpc=%0d state=%0d got=%h exp=%h", bpc_of[idx], s, d, model_inv(din));
                end
                n_cmp++;
                if (lat != 16 / bpc_of[idx]) begin
                    n_fail++; $display("FAIL sweep_latency bpc=%0d got=%0d exp=%0d", bpc_of[idx], lat, 16 / bpc_of[idx]);
                end
            end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        logic [127:0] d;
        int lat;
        bit to;
        for (int i = 0; i < 1000; i++) begin
            orig = rand_state();
            do_txn(i % 5, model_fwd(orig), d, lat, to);
            n_cmp++;
            if (to || d !== orig) begin
                n_fail++; $display("FAIL round_trip i=%0d bpc=%0d got=%h exp=%h", i, bpc_of[i % 5], d, orig);
            end
        end
    endtask

    task automatic init_bus();
        if_b1.in_valid = 0;  if_b1.in_data = '0;  if_b1.out_ready = 0;
        if_b2.in_valid = 0;  if_b2.in_data = '0;  if_b2.out_ready = 0;
        if_b4.in_valid = 0;  if_b4.in_data = '0;  if_b4.out_ready = 0;
        if_b8.in_valid = 0;  if_b8.in_data = '0;  if_b8.out_ready = 0;
        if_b16.in_valid = 0; if_b16.in_data = '0; if_b16.out_ready = 0;
    endtask

    initial begin
        init_bus();
        for (int x = 0; x < 256; x++) fwd_tbl[x] = ref_fwd(x);
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
